// File: rtl/l2_tag_ctrl.sv
// l2_tag_ctrl: controller for the single-port L2 tag SRAM.
// Clears the 16-set array after reset, looks up tags for L2 requests
// (hit/miss + victim info), marks lines dirty on store hits and
// installs tags on refills.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_*                   lookup request (valid/ready, addr, we)
//   fill_*                  refill tag install (valid/ready, addr, dirty)
//   resp_*                  registered one-cycle response pulse + victim info
//   tag_csb/web/addr/din    SRAM controls (active-low csb/web)
//   tag_dout                SRAM read word {valid, dirty, tag}
//   perf_hits/perf_misses   lookup counters, only with L2_TAG_PERF_EN
//
// Optional feature macro: L2_TAG_PERF_EN (adds the perf counters).
module l2_tag_ctrl #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 6,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = ADDR_W - IDX_W - OFF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_dirty,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic              resp_victim_valid,
    output logic              resp_victim_dirty,
    output logic [TAG_W-1:0]  resp_victim_tag,
    output logic              tag_csb,
    output logic              tag_web,
    output logic [IDX_W-1:0]  tag_addr,
    output logic [TAG_W+1:0]  tag_din,
    input  logic [TAG_W+1:0]  tag_dout
`ifdef L2_TAG_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_COMPARE,
        S_MARK
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  init_cnt;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic              lat_we;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;

    logic              dout_valid;
    logic              dout_dirty;
    logic [TAG_W-1:0]  dout_tag;
    logic              hit;

    // Line offset bits never reach the tag array.
    logic              unused_off;

    assign req_idx  = req_addr[OFF_W +: IDX_W];
    assign req_tag  = req_addr[OFF_W+IDX_W +: TAG_W];
    assign fill_idx = fill_addr[OFF_W +: IDX_W];
    assign fill_tag = fill_addr[OFF_W+IDX_W +: TAG_W];

    assign unused_off = ^{req_addr[OFF_W-1:0], fill_addr[OFF_W-1:0]};

    assign dout_valid = tag_dout[TAG_W+1];
    assign dout_dirty = tag_dout[TAG_W];
    assign dout_tag   = tag_dout[TAG_W-1:0];
    assign hit        = dout_valid && (dout_tag == lat_tag);

    // SRAM controls and handshakes decode the registered state.
    // Everything is held inactive while reset is asserted.
    always_comb begin
        tag_csb    = 1'b1;
        tag_web    = 1'b1;
        tag_addr   = '0;
        tag_din    = '0;
        req_ready  = 1'b0;
        fill_ready = 1'b0;
        if (rst_n) begin
            unique case (state)
                S_INIT: begin
                    tag_csb  = 1'b0;
                    tag_web  = 1'b0;
                    tag_addr = init_cnt;
                end
                S_IDLE: begin
                    if (fill_valid) begin
                        // Refill wins over a lookup in the same cycle.
                        fill_ready = 1'b1;
                        tag_csb    = 1'b0;
                        tag_web    = 1'b0;
                        tag_addr   = fill_idx;
                        tag_din    = {1'b1, fill_dirty, fill_tag};
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid) begin
                            tag_csb  = 1'b0;
                            tag_addr = req_idx;
                        end
                    end
                end
                S_COMPARE: begin
                end
                S_MARK: begin
                    tag_csb  = 1'b0;
                    tag_web  = 1'b0;
                    tag_addr = lat_idx;
                    tag_din  = {2'b11, lat_tag};
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_INIT;
            init_cnt          <= '0;
            lat_idx           <= '0;
            lat_tag           <= '0;
            lat_we            <= 1'b0;
            resp_valid        <= 1'b0;
            resp_hit          <= 1'b0;
            resp_victim_valid <= 1'b0;
            resp_victim_dirty <= 1'b0;
            resp_victim_tag   <= '0;
`ifdef L2_TAG_PERF_EN
            perf_hits         <= '0;
            perf_misses       <= '0;
`endif
        end else begin
            resp_valid <= 1'b0;
            unique case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!fill_valid && req_valid) begin
                        lat_idx <= req_idx;
                        lat_tag <= req_tag;
                        lat_we  <= req_we;
                        state   <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    // tag_dout holds the word read in the accept cycle.
                    resp_valid        <= 1'b1;
                    resp_hit          <= hit;
                    resp_victim_valid <= dout_valid;
                    resp_victim_dirty <= dout_dirty;
                    resp_victim_tag   <= dout_tag;
`ifdef L2_TAG_PERF_EN
                    if (hit) begin
                        perf_hits <= perf_hits + 32'd1;
                    end else begin
                        perf_misses <= perf_misses + 32'd1;
                    end
`endif
                    // Only a clean store hit needs the dirty bit set.
                    if (lat_we && hit && !dout_dirty) begin
                        state <= S_MARK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MARK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// tb_l2_tag_ctrl: self-checking bench for l2_tag_ctrl.
// Behavioural SRAM + set-array model, directed and random traffic.
module tb_l2_tag_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_we = 1'b0;
    logic        fill_valid = 1'b0;
    logic        fill_ready;
    logic [31:0] fill_addr = '0;
    logic        fill_dirty = 1'b0;
    logic        resp_valid;
    logic        resp_hit;
    logic        resp_victim_valid;
    logic        resp_victim_dirty;
    logic [21:0] resp_victim_tag;
    logic        tag_csb;
    logic        tag_web;
    logic [3:0]  tag_addr;
    logic [23:0] tag_din;
    logic [23:0] tag_dout;

    always #5 clk = ~clk;

    l2_tag_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_we            (req_we),
        .fill_valid        (fill_valid),
        .fill_ready        (fill_ready),
        .fill_addr         (fill_addr),
        .fill_dirty        (fill_dirty),
        .resp_valid        (resp_valid),
        .resp_hit          (resp_hit),
        .resp_victim_valid (resp_victim_valid),
        .resp_victim_dirty (resp_victim_dirty),
        .resp_victim_tag   (resp_victim_tag),
        .tag_csb           (tag_csb),
        .tag_web           (tag_web),
        .tag_addr          (tag_addr),
        .tag_din           (tag_din),
        .tag_dout          (tag_dout)
    );

    // Behavioural single-port SRAM, starts with garbage.
    logic [23:0] mem [16];
    logic [23:0] sram_q = '0;
    logic        mem_seeded = 1'b0;

    always @(posedge clk) begin
        if (!mem_seeded) begin
            for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
            mem_seeded = 1'b1;
        end
        if (!tag_csb) begin
            if (!tag_web) mem[tag_addr] <= tag_din;
            else sram_q <= mem[tag_addr];
        end
    end
    assign tag_dout = sram_q;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference model: per-set contents and expected responses.
    typedef struct {
        int          due;
        logic        hit;
        logic        vv;
        logic        vd;
        logic [21:0] vt;
    } exp_t;

    logic        mv [16];
    logic        md [16];
    logic [21:0] mt [16];
    exp_t        q [$];
    int          cyc = 0;
    int          busy_until = 17;
    int          mark_due = -1;
    logic [3:0]  mark_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0;
            busy_until = 17;
            mark_due = -1;
            q.delete();
            for (int i = 0; i < 16; i++) begin
                mv[i] = 1'b0;
                md[i] = 1'b0;
                mt[i] = '0;
            end
        end else begin
            logic    en;
            logic    efr;
            logic    err;
            logic [3:0]  ix;
            logic [21:0] tg;
            exp_t    e;
            cyc++;
            if (cyc <= 16) begin
                chk("init_csb", tag_csb, 0);
                chk("init_web", tag_web, 0);
                chk("init_addr", tag_addr, cyc - 1);
                chk("init_din", tag_din, 0);
            end
            en  = (cyc >= busy_until);
            efr = en && fill_valid;
            err = en && !fill_valid;
            chk("fill_ready", fill_ready, efr);
            chk("req_ready", req_ready, err);
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("resp_valid", resp_valid, 1);
                chk("resp_hit", resp_hit, e.hit);
                chk("resp_vv", resp_victim_valid, e.vv);
                chk("resp_vd", resp_victim_dirty, e.vd);
                chk("resp_vt", resp_victim_tag, e.vt);
            end else begin
                chk("resp_idle", resp_valid, 0);
            end
            if (mark_due == cyc) begin
                chk("mark_csb", tag_csb, 0);
                chk("mark_web", tag_web, 0);
                chk("mark_addr", tag_addr, mark_idx);
                chk("mark_din", tag_din, {2'b11, mt[mark_idx]});
                mark_due = -1;
            end
            if (fill_valid && efr) begin
                ix = fill_addr[9:6];
                mv[ix] = 1'b1;
                md[ix] = fill_dirty;
                mt[ix] = fill_addr[31:10];
                busy_until = cyc + 1;
            end else if (req_valid && err) begin
                ix = req_addr[9:6];
                tg = req_addr[31:10];
                e.due = cyc + 2;
                e.hit = mv[ix] && (mt[ix] == tg);
                e.vv = mv[ix];
                e.vd = md[ix];
                e.vt = mt[ix];
                q.push_back(e);
                busy_until = cyc + 2;
                if (req_we && e.hit && !md[ix]) begin
                    md[ix] = 1'b1;
                    mark_due = cyc + 2;
                    mark_idx = ix;
                    busy_until = cyc + 3;
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic we,
                          output int acc);
        int n;
        n = 0;
        acc = -1;
        @(posedge clk);
        #1;
        req_addr = a;
        req_we = we;
        req_valid = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (req_ready) begin
                acc = cyc;
                break;
            end
            n++;
            if (n > 50) begin
                chk("req_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_fill(input logic [31:0] a, input logic d);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        fill_addr = a;
        fill_dirty = d;
        fill_valid = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (fill_ready) break;
            n++;
            if (n > 50) begin
                chk("fill_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
    endtask

    logic        r_hit;
    logic        r_vv;
    logic        r_vd;
    logic [21:0] r_vt;
    int          r_cyc;
    logic [29:0] r_sig;

    // r_sig = {csb, web, addr, din} seen in the response cycle.
    task automatic wait_resp();
        r_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (resp_valid) begin
                r_hit = resp_hit;
                r_vv = resp_victim_valid;
                r_vd = resp_victim_dirty;
                r_vt = resp_victim_tag;
                r_cyc = cyc;
                r_sig = {tag_csb, tag_web, tag_addr, tag_din};
                break;
            end
        end
        if (r_cyc < 0) chk("resp_timeout", 0, 1);
    endtask

    initial begin
        int a;
        logic [31:0] ra;

        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b1;
        fill_valid = 1'b1;
        #1;
        chk("rst_csb", tag_csb, 1);
        chk("rst_web", tag_web, 1);
        chk("rst_addr", tag_addr, 0);
        chk("rst_din", tag_din, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fill_ready", fill_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        req_valid = 1'b0;
        fill_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First lookup after the sweep: cold miss.
        do_req(32'h0000_1040, 1'b0, a);
        chk("first_accept_cyc", a, 17);
        wait_resp();
        chk("cold_latency", r_cyc - a, 2);
        chk("cold_hit", r_hit, 0);
        chk("cold_vv", r_vv, 0);

        do_fill(32'h0000_1040, 1'b0);
        do_req(32'h0000_1040, 1'b0, a);
        wait_resp();
        chk("ld_hit", r_hit, 1);
        chk("ld_vt", r_vt, 22'h4);

        do_req(32'h0000_1040, 1'b1, a);
        wait_resp();
        chk("st_hit", r_hit, 1);
        chk("st_vd", r_vd, 0);
        chk("mark_word", r_sig, {2'b00, 4'h1, 24'hC00004});

        do_req(32'h0000_1040, 1'b0, a);
        wait_resp();
        chk("after_mark_vd", r_vd, 1);

        do_fill(32'h0000_1040, 1'b1);
        do_req(32'h0001_1040, 1'b0, a);
        wait_resp();
        chk("conf_hit", r_hit, 0);
        chk("conf_vv", r_vv, 1);
        chk("conf_vd", r_vd, 1);
        chk("conf_vt", r_vt, 22'h4);

        // Fill and lookup in the same cycle.
        @(posedge clk);
        #1;
        fill_addr = 32'h0000_2080;
        fill_dirty = 1'b0;
        fill_valid = 1'b1;
        req_addr = 32'h0000_2080;
        req_we = 1'b0;
        req_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("both_fill_ready", fill_ready, 1);
        chk("both_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("next_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_resp();
        chk("raw_hit", r_hit, 1);

        // Reset while a lookup is in COMPARE.
        do_req(32'h0000_1040, 1'b0, a);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_drop_resp", resp_valid, 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_req(32'h0000_1040, 1'b0, a);
        chk("rerst_accept_cyc", a, 17);
        wait_resp();
        chk("rerst_hit", r_hit, 0);
        chk("rerst_vv", r_vv, 0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            ra = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  6'($urandom)};
            fill_addr = ra;
            fill_dirty = 1'($urandom);
            fill_valid = ($urandom_range(0, 3) == 0);
            ra = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                  6'($urandom)};
            req_addr = ra;
            req_we = 1'($urandom);
            req_valid = 1'($urandom);
        end
        @(posedge clk);
        #1;
        fill_valid = 1'b0;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
